// File: rtl/fifo4x16_if.sv
// Handshake and status bundle for the 4x16 FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo4x16_if;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        almost_full;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, almost_full
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, almost_full
    );
endinterface

// File: rtl/fifo4x16.sv
// 4-entry, 16-bit synchronous FIFO; the head word is selected from the four
// storage registers by a Mux4Way16 driven with the read pointer.

module mux4way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        out = a;
        case (sel)
            2'd0: out = a;
            2'd1: out = b;
            2'd2: out = c;
            2'd3: out = d;
            default: out = a;
        endcase
    end
endmodule

module fifo4x16 #(
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo4x16_if.slave   bus
);
    logic [15:0] mem_q [4];
    logic [15:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        push, pop;
    logic [15:0] head_data;

    // Valid/ready: a word moves on a side only in a cycle where both valid and
    // ready are high at the rising edge; ready never depends on the other side.
    assign bus.in_ready    = (count_q != 3'd4);
    assign bus.out_valid   = (count_q != 3'd0);
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= 3'(AF_LEVEL));
    assign bus.out_data    = head_data;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    mux4way16 u_read_mux (
        .a   (mem_q[0]),
        .b   (mem_q[1]),
        .c   (mem_q[2]),
        .d   (mem_q[3]),
        .sel (rd_ptr_q),
        .out (head_data)
    );

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any handshake; storage is left as-is since count=0 hides it.
        if (bus.flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.in_data;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
